// File: rtl/fetch_unit.sv
// Front-end sequencer of the accumulator CPU: owns PC and IR, fetches from a
// synchronous instruction ROM and hands op/operand to the control unit.
module fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [7:0]         op,
    output logic [ADDR_W-1:0]  operand_addr,
    input  logic [2:0]         pc_mode,
    output logic               exec_en,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic [15:0]        retired
);

    // Next-PC encodings shared with the control unit (define.v).
    localparam logic [2:0] PC_MODE_NORMAL = 3'd0;
    localparam logic [2:0] PC_MODE_JUMP   = 3'd1;
    localparam logic [2:0] PC_MODE_STOP   = 3'd2;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]         state;
    logic [INSTR_W-1:0] ir;

    assign imem_addr    = pc;
    assign op           = ir[INSTR_W-1 -: 8];
    assign operand_addr = ir[ADDR_W-1:0];
    assign exec_en      = (state == S_EXEC);
    assign halted       = (state == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        state <= S_LOAD;
                    end
                end
                // ROM data for pc becomes valid here, one cycle after the address.
                S_LOAD: begin
                    ir    <= imem_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    retired <= retired + 16'd1;
                    case (pc_mode)
                        PC_MODE_JUMP: begin
                            pc    <= operand_addr;
                            state <= S_FETCH;
                        end
                        PC_MODE_STOP: begin
                            state <= S_HALT;
                        end
                        // Normal and every unknown encoding advance sequentially.
                        default: begin
                            pc    <= pc + ADDR_W'(1);
                            state <= S_FETCH;
                        end
                    endcase
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model walks the ROM program and
// queues expected executions; a monitor compares each exec_en pulse.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, run;
    logic [7:0]  imem_addr, op, operand_addr, pc;
    logic [15:0] imem_rdata, retired;
    logic [2:0]  pc_mode;
    logic        exec_en, halted;

    // Second instance built with RESET_PC = 0xFF for the wrap case.
    logic        w_rst, w_run;
    logic [7:0]  w_imem_addr, w_op, w_operand_addr, w_pc;
    logic [15:0] w_imem_rdata, w_retired;
    logic [2:0]  w_pc_mode;
    logic        w_exec_en, w_halted;

    logic [15:0] rom [256];

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  op;
        logic [7:0]  opnd;
        logic [15:0] ret;
    } exp_t;
    exp_t sb[$];

    int   checks = 0;
    int   failures = 0;
    logic m_halts;
    logic prev_exec = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .op(op), .operand_addr(operand_addr), .pc_mode(pc_mode), .exec_en(exec_en),
        .pc(pc), .halted(halted), .retired(retired)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(255)) u_wrap (
        .clk(clk), .rst(w_rst), .run(w_run), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .op(w_op), .operand_addr(w_operand_addr), .pc_mode(w_pc_mode), .exec_en(w_exec_en),
        .pc(w_pc), .halted(w_halted), .retired(w_retired)
    );

    // Synchronous ROMs and a combinational control-unit stand-in.
    always @(posedge clk) imem_rdata   <= rom[imem_addr];
    always @(posedge clk) w_imem_rdata <= rom[w_imem_addr];

    function automatic logic [2:0] mode_of(input logic [7:0] o);
        if (o == 8'h0A)      return 3'd1;  // jump
        else if (o == 8'hFF) return 3'd2;  // stop
        else if (o == 8'h0B) return 3'd7;  // undefined encoding, behaves as normal
        else                 return 3'd0;
    endfunction

    always_comb pc_mode   = mode_of(op);
    always_comb w_pc_mode = mode_of(w_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every execute pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (exec_en === 1'b1) begin
            exp_t e;
            check("exec_width", prev_exec, 0);
            if (sb.size() == 0) begin
                check("unexpected_exec", 1, 0);
            end else begin
                e = sb.pop_front();
                check("exec_pc", pc, e.pc);
                check("exec_op", op, e.op);
                check("exec_operand", operand_addr, e.opnd);
                check("exec_retired", retired, e.ret);
            end
        end
        prev_exec = exec_en;
    end

    // Reference model: step through the program from the reset PC by the ISA rules.
    task automatic build_model(input int n);
        int pc_m = 0;
        int ret_m = 0;
        sb.delete();
        m_halts = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            logic [15:0] w;
            w      = rom[pc_m];
            e.pc   = 8'(pc_m);
            e.op   = w[15:8];
            e.opnd = w[7:0];
            e.ret  = 16'(ret_m);
            sb.push_back(e);
            ret_m++;
            if (e.op == 8'hFF) begin
                m_halts = 1'b1;
                break;
            end else if (e.op == 8'h0A) begin
                pc_m = int'(e.opnd);
            end else begin
                pc_m = (pc_m + 1) % 256;
            end
        end
    endtask

    task automatic start_prog(input int n);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        build_model(n);
    endtask

    task automatic run_prog();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 || halted) break;
            run = ($urandom_range(0, 3) != 0);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("drain", sb.size(), 0);
        check("halt_state", halted, m_halts);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        logic quiet;
        rst = 1'b1; run = 1'b0; w_rst = 1'b1; w_run = 1'b0;
        clear_rom();

        // Basic sequencing, jump, run gating and reset mid-EXEC.
        rom[0] = 16'h0005; rom[1] = 16'h0A40; rom[8'h40] = 16'h0B00;
        start_prog(20);
        check("rst_pc", pc, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_op", op, 0);
        check("rst_operand", operand_addr, 0);
        check("rst_exec_en", exec_en, 0);
        check("rst_halted", halted, 0);
        check("rst_retired", retired, 0);
        run = 1'b1;
        @(negedge clk); check("load_no_exec", exec_en, 0);
        @(negedge clk); check("exec_latency", exec_en, 1);
        @(negedge clk);
        check("normal_pc", pc, 1);
        check("normal_retired", retired, 1);
        check("normal_exec_off", exec_en, 0);
        repeat (3) @(negedge clk);
        check("jump_pc", pc, 8'h40);
        check("jump_imem_addr", imem_addr, 8'h40);
        run = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (exec_en !== 1'b0 || imem_addr !== 8'h40) quiet = 1'b0;
        end
        check("gate_idle", quiet, 1);
        check("gate_retired", retired, 2);
        run = 1'b1;
        @(negedge clk); check("resume_load", exec_en, 0);
        @(negedge clk); check("resume_exec", exec_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        check("rexec_pc", pc, 0);
        check("rexec_retired", retired, 0);
        check("rexec_halted", halted, 0);
        check("rexec_exec_en", exec_en, 0);
        check("rexec_op", op, 0);

        // Stop at pc 3, hold in HALT with run high, then reset out of HALT.
        clear_rom();
        rom[0] = 16'h0001; rom[1] = 16'h0102; rom[2] = 16'h0203; rom[3] = 16'hFF00;
        start_prog(50);
        run = 1'b1;
        for (int c = 0; c < 40 && halted !== 1'b1; c++) @(negedge clk);
        check("stop_halted", halted, 1);
        check("stop_pc", pc, 3);
        check("stop_retired", retired, 4);
        check("stop_drain", sb.size(), 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("halt_pc", pc, 3);
            check("halt_exec_en", exec_en, 0);
            check("halt_hold", halted, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        check("rhalt_pc", pc, 0);
        check("rhalt_halted", halted, 0);
        check("rhalt_retired", retired, 0);
        check("rhalt_exec_en", exec_en, 0);

        // Wrap from 0xFF: reset-PC instance, and a jump to 0xFF on the main one.
        clear_rom();
        w_rst = 1'b1;
        @(negedge clk);
        w_rst = 1'b0;
        check("wrap_rst_pc", w_pc, 8'hFF);
        check("wrap_rst_imem", w_imem_addr, 8'hFF);
        w_run = 1'b1;
        repeat (3) @(negedge clk);
        w_run = 1'b0;
        check("wrap_pc", w_pc, 8'h00);
        check("wrap_retired", w_retired, 1);
        rom[0] = 16'h0AFF; rom[8'hFF] = 16'h0B11;
        start_prog(10);
        run_prog();

        // Randomized programs.
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 256; i++) begin
                int r;
                logic [7:0] o;
                r = $urandom_range(0, 15);
                if (r <= 9)       o = 8'(r);
                else if (r <= 11) o = 8'h0A;
                else if (r == 12) o = 8'h0B;
                else if (r <= 14) o = 8'($urandom_range(16, 254));
                else              o = 8'hFF;
                rom[i] = {o, 8'($urandom_range(0, 255))};
            end
            start_prog(30);
            run_prog();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
